// File: rtl/uc_rr_collector_if.sv
// Handshake bundle between the engine UC queues, the collector and the downstream consumer.
// The master side drives engine heads and downstream ready; the slave side is the collector.
interface uc_rr_collector_if #(
   parameter int unsigned NUM_ENG = 4,
   parameter int unsigned LIT_W   = 16,
   parameter int unsigned DEPTH   = 8
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic                             flush;
   logic                             input_mode;
   logic [NUM_ENG-1:0]               eng_mask;
   logic [NUM_ENG-1:0]               eng_valid;
   logic [NUM_ENG-1:0][LIT_W-1:0]    eng_lit;
   logic [NUM_ENG-1:0]               eng_pop;
   logic [LIT_W-1:0]                 out_lit;
   logic                             out_valid;
   logic                             out_ready;
   logic [LIT_W-1:0]                 gst_lit;
   logic                             gst_valid;
   logic                             conflict;
   logic [LIT_W-1:0]                 conflict_lit;
   logic [CNT_W-1:0]                 count;

   modport master (
      output flush, input_mode, eng_mask, eng_valid, eng_lit, out_ready,
      input  eng_pop, out_lit, out_valid, gst_lit, gst_valid, conflict, conflict_lit, count
   );

   modport slave (
      input  flush, input_mode, eng_mask, eng_valid, eng_lit, out_ready,
      output eng_pop, out_lit, out_valid, gst_lit, gst_valid, conflict, conflict_lit, count
   );
endinterface

// File: rtl/uc_rr_collector.sv
// Collects unit-clause literals from several engine queues into one de-duplicated FIFO,
// dropping duplicates and invalid literals and latching the first polarity conflict.
module uc_rr_collector #(
   parameter int unsigned NUM_ENG = 4,
   parameter int unsigned LIT_W   = 16,
   parameter int unsigned DEPTH   = 8
) (
   input logic                clk,
   input logic                rst,
   uc_rr_collector_if.slave   bus
);
   localparam int unsigned ENG_W = $clog2(NUM_ENG);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned IDX_W = LIT_W - 1;

   logic [LIT_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_conflict;
   logic [LIT_W-1:0]  r_conflict_lit;
   logic [ENG_W-1:0]  r_rr_ptr;

   logic              w_allow;
   logic              w_rr_hit;
   logic [ENG_W-1:0]  w_rr_idx;
   logic              w_mask_onehot;
   logic              w_mask_hit;
   logic [ENG_W-1:0]  w_mask_idx;
   logic              w_grant;
   logic [ENG_W-1:0]  w_gnt_idx;
   logic [LIT_W-1:0]  w_lit;
   logic [LIT_W-1:0]  w_lit_neg;
   logic              w_zero;
   logic              w_dup;
   logic              w_opp;
   logic              w_push;
   logic              w_set_conflict;
   logic              w_pop;

   // A full FIFO blocks grants even if the head leaves this cycle.
   assign w_allow = (r_count < CNT_W'(DEPTH)) && !r_conflict && !bus.flush && !rst;

   // Round-robin search starting at r_rr_ptr; index arithmetic wraps in ENG_W bits.
   always_comb begin
      logic [ENG_W-1:0] cand;
      w_rr_hit = 1'b0;
      w_rr_idx = '0;
      cand     = '0;
      for (int i = 0; i < int'(NUM_ENG); i++) begin
         cand = r_rr_ptr + ENG_W'(i);
         if (!w_rr_hit && bus.eng_valid[cand]) begin
            w_rr_hit = 1'b1;
            w_rr_idx = cand;
         end
      end
   end

   assign w_mask_onehot = (bus.eng_mask != '0) &&
                          ((bus.eng_mask & (bus.eng_mask - NUM_ENG'(1))) == '0);

   always_comb begin
      w_mask_idx = '0;
      for (int k = 0; k < int'(NUM_ENG); k++) begin
         if (bus.eng_mask[k]) w_mask_idx = ENG_W'(k);
      end
   end

   assign w_mask_hit = w_mask_onehot && ((bus.eng_mask & bus.eng_valid) != '0);
   assign w_grant    = w_allow && (bus.input_mode ? w_rr_hit : w_mask_hit);
   assign w_gnt_idx  = bus.input_mode ? w_rr_idx : w_mask_idx;
   assign w_lit      = bus.eng_lit[w_gnt_idx];
   assign w_lit_neg  = {~w_lit[LIT_W-1], w_lit[IDX_W-1:0]};
   assign w_zero     = (w_lit[IDX_W-1:0] == '0);

   // Compare against every occupied slot, including a head leaving this cycle.
   always_comb begin
      logic [PTR_W-1:0] slot;
      w_dup = 1'b0;
      w_opp = 1'b0;
      slot  = '0;
      for (int j = 0; j < int'(DEPTH); j++) begin
         slot = r_rd_ptr + PTR_W'(j);
         if (CNT_W'(j) < r_count) begin
            if (r_mem[slot] == w_lit)     w_dup = 1'b1;
            if (r_mem[slot] == w_lit_neg) w_opp = 1'b1;
         end
      end
   end

   assign w_push         = w_grant && !w_zero && !w_dup && !w_opp;
   assign w_set_conflict = w_grant && !w_zero && !w_dup && w_opp;
   assign w_pop          = (r_count != '0) && bus.out_ready && !bus.flush && !rst;

   assign bus.eng_pop      = w_grant ? (NUM_ENG'(1) << w_gnt_idx) : '0;
   assign bus.gst_valid    = w_push;
   assign bus.gst_lit      = w_push ? w_lit : '0;
   assign bus.out_valid    = (r_count != '0);
   assign bus.out_lit      = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign bus.conflict     = r_conflict;
   assign bus.conflict_lit = r_conflict_lit;
   assign bus.count        = r_count;

   // Storage needs no reset: out_lit is gated by occupancy.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_lit;
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_rd_ptr       <= '0;
         r_wr_ptr       <= '0;
         r_count        <= '0;
         r_conflict     <= 1'b0;
         r_conflict_lit <= '0;
         r_rr_ptr       <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
         if (w_set_conflict) begin
            r_conflict     <= 1'b1;
            r_conflict_lit <= w_lit;
         end
         if (w_grant && bus.input_mode) r_rr_ptr <= w_gnt_idx + ENG_W'(1);
      end
   end
endmodule

// File: tb/tb_uc_rr_collector.sv
// Directed and random stimulus for uc_rr_collector against a queue-based reference model.
module tb_uc_rr_collector;
   localparam int unsigned NE = 4;
   localparam int unsigned LW = 16;
   localparam int unsigned DP = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uc_rr_collector_if #(.NUM_ENG(NE), .LIT_W(LW), .DEPTH(DP)) bus ();
   uc_rr_collector #(.NUM_ENG(NE), .LIT_W(LW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [15:0] mq[$];
   bit          m_conf;
   logic [15:0] m_conf_lit;
   int          m_rr;

   // DUT observations captured by the last step
   logic [3:0]  dut_pop;
   logic        dut_gst;
   logic [3:0]  dut_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic a_rst, input logic a_flush, input logic a_mode,
                       input logic [3:0] a_mask, input logic [3:0] a_valid,
                       input logic [3:0][15:0] a_lit, input logic a_ready);
      int g;
      logic [15:0] L;
      bit dup, opp, zero, push, conf;
      @(negedge clk);
      rst            = a_rst;
      bus.flush      = a_flush;
      bus.input_mode = a_mode;
      bus.eng_mask   = a_mask;
      bus.eng_valid  = a_valid;
      bus.eng_lit    = a_lit;
      bus.out_ready  = a_ready;
      #1;
      dut_pop   = bus.eng_pop;
      dut_gst   = bus.gst_valid;
      dut_count = bus.count;

      check("count",        32'(bus.count),        32'(mq.size()));
      check("out_valid",    32'(bus.out_valid),    32'(mq.size() != 0));
      check("out_lit",      32'(bus.out_lit),      32'((mq.size() != 0) ? mq[0] : 16'h0));
      check("conflict",     32'(bus.conflict),     32'(m_conf));
      check("conflict_lit", 32'(bus.conflict_lit), 32'(m_conf_lit));

      g = -1;
      if (!a_rst && !a_flush && !m_conf && mq.size() < DP) begin
         if (a_mode) begin
            for (int k = 0; k < int'(NE); k++) begin
               int e;
               e = (m_rr + k) % NE;
               if (g < 0 && a_valid[e]) g = e;
            end
         end else if ($countones(a_mask) == 1) begin
            for (int k = 0; k < int'(NE); k++)
               if (a_mask[k] && a_valid[k]) g = k;
         end
      end

      L = (g >= 0) ? a_lit[g] : 16'h0;
      zero = (L[14:0] == 15'h0);
      dup = 0; opp = 0;
      foreach (mq[i]) begin
         if (mq[i] == L) dup = 1;
         if (mq[i] == {~L[15], L[14:0]}) opp = 1;
      end
      push = (g >= 0) && !zero && !dup && !opp;
      conf = (g >= 0) && !zero && !dup && opp;

      check("eng_pop",   32'(bus.eng_pop),   (g >= 0) ? (32'd1 << g) : 32'd0);
      check("gst_valid", 32'(bus.gst_valid), 32'(push));
      if (push) check("gst_lit", 32'(bus.gst_lit), 32'(L));

      if (a_rst || a_flush) begin
         mq.delete();
         m_conf = 0; m_conf_lit = 16'h0; m_rr = 0;
      end else begin
         if (mq.size() != 0 && a_ready) void'(mq.pop_front());
         if (push) mq.push_back(L);
         if (conf) begin m_conf = 1; m_conf_lit = L; end
         if (a_mode && g >= 0) m_rr = (g + 1) % NE;
      end
   endtask

   function automatic logic [15:0] rlit();
      return {1'($urandom_range(0, 1)), 12'h0, 3'($urandom_range(0, 7))};
   endfunction

   initial begin
      logic [3:0][15:0] lits;
      rst = 1'b1;
      bus.flush = 0; bus.input_mode = 0; bus.eng_mask = 0; bus.eng_valid = 0;
      bus.eng_lit = '0; bus.out_ready = 0;
      mq.delete(); m_conf = 0; m_conf_lit = 16'h0; m_rr = 0;
      repeat (2) @(posedge clk);

      // Reset state, then round-robin fairness
      step(0, 0, 1, 4'h0, 4'h0, '0, 1);
      lits = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      step(0, 0, 1, 4'h0, 4'hF, lits, 1); check("rr_g0", 32'(dut_pop), 32'h1);
      step(0, 0, 1, 4'h0, 4'hF, lits, 1); check("rr_g1", 32'(dut_pop), 32'h2);
      step(0, 0, 1, 4'h0, 4'hF, lits, 1); check("rr_g2", 32'(dut_pop), 32'h4);
      step(0, 0, 1, 4'h0, 4'hF, lits, 1); check("rr_g3", 32'(dut_pop), 32'h8);
      step(0, 0, 1, 4'h0, 4'hF, lits, 1); check("rr_g4", 32'(dut_pop), 32'h1);

      // Duplicate drop
      step(0, 1, 0, 4'h0, 4'h0, '0, 0);
      lits = {16'h0, 16'h0, 16'h0, 16'h0005};
      step(0, 0, 0, 4'b0001, 4'b0001, lits, 0);
      lits = {16'h0009, 16'h0005, 16'h000A, 16'h000B};
      step(0, 0, 0, 4'b0100, 4'hF, lits, 0);
      check("dup_pop", 32'(dut_pop), 32'h4);
      check("dup_gst", 32'(dut_gst), 32'h0);

      // Conflict is sticky until flush
      lits = {16'h0009, 16'h000A, 16'h8005, 16'h000B};
      step(0, 0, 0, 4'b0010, 4'hF, lits, 0); check("conf_pop", 32'(dut_pop), 32'h2);
      step(0, 0, 1, 4'h0, 4'hF, lits, 0);    check("conf_hold0", 32'(dut_pop), 32'h0);
      step(0, 0, 1, 4'h0, 4'hF, lits, 1);    check("conf_hold1", 32'(dut_pop), 32'h0);
      step(0, 1, 1, 4'h0, 4'hF, lits, 1);    check("flush_pop", 32'(dut_pop), 32'h0);
      step(0, 0, 1, 4'h0, 4'h0, lits, 0);    check("flush_cnt", 32'(dut_count), 32'h0);

      // Full FIFO blocks grants, even alongside a downstream pop
      step(0, 1, 0, 4'h0, 4'h0, '0, 0);
      for (int s = 0; s < 8; s++) begin
         for (int e = 0; e < 4; e++) lits[e] = 16'(16'h0100 + s * 4 + e);
         step(0, 0, 1, 4'h0, 4'hF, lits, 0);
      end
      lits = {16'h0203, 16'h0202, 16'h0201, 16'h0200};
      step(0, 0, 1, 4'h0, 4'hF, lits, 0);
      check("full_cnt", 32'(dut_count), 32'h8); check("full_pop", 32'(dut_pop), 32'h0);
      step(0, 0, 1, 4'h0, 4'hF, lits, 1);  check("full_pop_rd", 32'(dut_pop), 32'h0);
      step(0, 0, 1, 4'h0, 4'hF, lits, 0);
      check("full_cnt7", 32'(dut_count), 32'h7); check("resume", 32'(dut_pop != 0), 32'h1);

      // Mask mode leaves the RR pointer alone
      step(0, 1, 0, 4'h0, 4'h0, '0, 1);
      lits = {16'h0304, 16'h0303, 16'h0302, 16'h0301};
      step(0, 0, 1, 4'h0, 4'hF, lits, 1);    check("pre_mask_rr", 32'(dut_pop), 32'h1);
      lits = {16'h0314, 16'h0313, 16'h0312, 16'h0311};
      step(0, 0, 0, 4'b0100, 4'hF, lits, 1); check("mask_one", 32'(dut_pop), 32'h4);
      step(0, 0, 0, 4'b0110, 4'hF, lits, 1); check("mask_multi", 32'(dut_pop), 32'h0);
      lits = {16'h0324, 16'h0323, 16'h0322, 16'h0321};
      step(0, 0, 1, 4'h0, 4'hF, lits, 1);    check("post_mask_rr", 32'(dut_pop), 32'h2);

      // Reset mid-stream discards contents
      step(0, 1, 0, 4'h0, 4'h0, '0, 0);
      for (int s = 0; s < 5; s++) begin
         for (int e = 0; e < 4; e++) lits[e] = 16'(16'h0400 + s * 4 + e);
         step(0, 0, 1, 4'h0, 4'hF, lits, 0);
      end
      step(1, 0, 1, 4'h0, 4'hF, lits, 1);
      check("rst_pre_cnt", 32'(dut_count), 32'h5); check("rst_pop", 32'(dut_pop), 32'h0);
      step(0, 0, 1, 4'h0, 4'h0, lits, 0);    check("rst_cnt", 32'(dut_count), 32'h0);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] msk;
         for (int e = 0; e < 4; e++) lits[e] = rlit();
         msk = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
              1'($urandom), msk, 4'($urandom), lits, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uc_rr_collector.md
UC_RR_COLLECTOR -- requirements
Module: uc_rr_collector

Interface
- REQ-001: Parameter NUM_ENG, default 4, number of engine UC output queues; SHALL be >=2 and a power of two.
- REQ-002: Parameter LIT_W, default 16, literal width; bit LIT_W-1 = polarity (1 = negated), bits LIT_W-2:0 = variable index; index 0 is invalid.
- REQ-003: Parameter DEPTH, default 8, output FIFO depth; SHALL be a power of two, >=2.
- REQ-004: clk  in  1  sole clock, all state updates on rising edge.
- REQ-005: rst  in  1  reset, synchronous, active-high.
- REQ-006: flush  in  1  synchronous clear of FIFO, conflict state and RR pointer.
- REQ-007: input_mode  in  1  0 = mask mode, 1 = round-robin mode.
- REQ-008: eng_mask  in  NUM_ENG  one-hot engine select for mask mode.
- REQ-009: eng_valid  in  NUM_ENG  engine i has a literal at its queue head.
- REQ-010: eng_lit  in  NUM_ENG x LIT_W  head literal of each engine queue.
- REQ-011: eng_pop  out  NUM_ENG  one-hot pop of the granted engine queue, combinational.
- REQ-012: out_lit  out  LIT_W  FIFO head literal.
- REQ-013: out_valid  out  1  FIFO not empty.
- REQ-014: out_ready  in  1  downstream accepts out_lit this cycle.
- REQ-015: gst_lit / gst_valid  out  LIT_W / 1  literal newly pushed into FIFO, for GST update.
- REQ-016: conflict  out  1  sticky conflict flag; conflict_lit  out  LIT_W  literal that caused it.
- REQ-017: count  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
- REQ-018: Grant at most one engine per cycle; a grant is allowed only when count < DEPTH, conflict = 0, flush = 0, rst = 0.
- REQ-019: No grant on a full FIFO, even when a downstream pop occurs the same cycle.
- REQ-020: Round-robin: search engines rr_ptr, rr_ptr+1, ... mod NUM_ENG; grant the first with eng_valid = 1.
- REQ-021: On a round-robin grant to engine g, rr_ptr <= (g+1) mod NUM_ENG; no grant leaves rr_ptr unchanged.
- REQ-022: Mask mode: grant engine k only if eng_mask is exactly one-hot at bit k and eng_valid[k] = 1; a zero or multi-hot mask gives no grant; rr_ptr is unchanged in mask mode.
- REQ-023: Granted engine: eng_pop[g] = 1 in the same cycle; the candidate literal L = eng_lit[g].
- REQ-024: L is compared against every FIFO entry present at cycle start, including a head popped this cycle.
- REQ-025: Variable index of L = 0 -> popped, dropped, no push, no flag.
- REQ-026: Exact match with an entry -> popped, dropped (duplicate), no push.
- REQ-027: Same variable, opposite polarity -> popped, not pushed; conflict <= 1, conflict_lit <= L next cycle.
- REQ-028: Conflict stays set until rst or flush.
- REQ-029: Otherwise L is pushed at the tail; gst_lit = L and gst_valid = 1 in the grant cycle; gst_valid = 0 in all other cycles.
- REQ-030: Latency: a literal pushed into an empty FIFO appears on out_lit with out_valid = 1 in the next cycle.
- REQ-031: Downstream pop when out_valid && out_ready; out_ready with an empty FIFO is ignored.
- REQ-032: Simultaneous push and pop (count < DEPTH) leaves count unchanged.
- REQ-033: Read and write pointers wrap modulo DEPTH.
- REQ-034: FIFO order is strict push order.
- REQ-035: flush = 1: eng_pop = 0 and gst_valid = 0 that cycle; next cycle count = 0, conflict = 0, conflict_lit = 0, rr_ptr = 0.
- REQ-036: A downstream pop during a flush cycle is discarded.
- REQ-037: A change of input_mode takes effect in the same cycle; there is no internal mode state.

Reset
- REQ-038: rst has priority over flush and all other inputs.
- REQ-039: Next cycle after rst: count = 0, out_valid = 0, out_lit = 0, conflict = 0, conflict_lit = 0, rr_ptr = 0.
- REQ-040: During rst, eng_pop = 0 and gst_valid = 0.
- REQ-041: rst asserted mid-operation discards FIFO contents with no pops issued.

Verification
- REQ-042: RR fairness: mode 1, eng_valid = 4'b1111 held, out_ready = 1 -> grants 0,1,2,3,0 on consecutive cycles with distinct literals 0x0001..0x0004; out_lit follows one cycle later.
- REQ-043: Duplicate: FIFO holds 0x0005, engine 2 offers 0x0005 -> eng_pop[2] = 1, gst_valid = 0, count stays 1.
- REQ-044: Conflict: FIFO holds 0x0005, engine 1 offers 0x8005 -> eng_pop[1] = 1, next cycle conflict = 1, conflict_lit = 0x8005; no further eng_pop until flush; after flush, count = 0 and conflict = 0.
- REQ-045: Full: out_ready = 0, 8 unique pushes -> count = 8, eng_pop = 0 with eng_valid high; out_ready = 1 for one cycle -> count 7, then a grant resumes.
- REQ-046: Mask mode: eng_mask = 4'b0100, eng_valid = 4'b1111 -> only eng_pop[2]; eng_mask = 4'b0110 -> no grant; rr_ptr unchanged across mask mode.
- REQ-047: Reset mid-stream: rst with count = 5 -> next cycle count = 0, out_valid = 0, conflict = 0.
